fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-side consumer of async_fifo, in the r_clk domain.
- Pops DATA_WIDTH-bit entries via the FIFO's r_en/r_data/empty interface and packs PACK consecutive entries into one wide word.
- Presents each word on a valid/ready master port.
- A timeout flushes a partially filled word when the FIFO stays empty, so trailing data never stalls.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (must match async_fifo DATA_WIDTH)
- PACK, 4, entries per output word (2..8)
- TIMEOUT, 16, consecutive starved cycles before a partial word is flushed (>=1)

Ports:
- r_clk  in  1  read-domain clock (same clock as async_fifo r_clk)
- r_rst  in  1  synchronous active-high reset
- fifo_empty  in  1  async_fifo empty flag
- fifo_r_en  out  1  pop request to async_fifo r_en
- fifo_r_data  in  DATA_WIDTH  async_fifo r_data, valid one cycle after an accepted pop
- m_data  out  DATA_WIDTH*PACK  packed word; entry k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- m_keep  out  PACK  per-lane valid mask for m_data
- m_valid  out  1  m_data/m_keep valid
- m_ready  in  1  downstream accepts word when m_valid && m_ready at posedge

Behaviour:
- Clock and reset:
  - One clock only.
  - Reset is synchronous and active-high: r_rst sampled at posedge r_clk.
  - While r_rst=1, fifo_r_en is forced to 0.
  - On reset: m_valid=0, m_data=0, m_keep=0, accumulator count cnt=0, inflight=0, idle counter=0.
  - A pop in flight when reset asserts is discarded.
- FIFO read contract:
  - Pop accepted in cycle N when fifo_r_en=1 and fifo_empty=0.
  - Data appears on fifo_r_data in cycle N+1 and is captured at the end of N+1.
  - inflight=1 in cycle N+1.
- Pop rule (combinational):
  - fifo_r_en = !r_rst && !fifo_empty && (cnt+inflight < PACK || (cnt==PACK-1 && inflight && slot_free)).
  - slot_free = !m_valid || m_ready.
  - Never pops while fifo_empty=1.
- Packing:
  - Captured entry is written to lane cnt, then cnt increments.
  - First entry goes in lane 0 (little-endian).
- Word complete (capture makes cnt==PACK):
  - If slot_free, the word loads into the output register on that same edge: m_valid=1, m_keep=all ones, cnt=0.
  - Otherwise the accumulator holds with cnt=PACK, and loads on the first edge with slot_free.
- Throughput and latency:
  - With a FIFO that is never empty and m_ready=1: sustained one pop per cycle, one word every PACK cycles.
  - First m_valid rises in cycle PACK+1 after the first pop (cycle 0).
- Output hold: while m_valid && !m_ready, m_data and m_keep are held stable. m_valid drops after acceptance unless a new word loads on the same edge (back-to-back allowed).
- Timeout:
  - idle counter increments each cycle in which 0<cnt<PACK, inflight=0 and fifo_empty=1.
  - Clears on any capture or any flush.
  - When idle reaches TIMEOUT and slot_free: flush the partial word.
    - m_keep low cnt bits =1; unused lanes =0 in both m_data and m_keep.
    - cnt=0.
  - If the slot is not free, the flush waits and idle saturates at TIMEOUT.
  - No flush when cnt=0.
- Simultaneous events:
  - Capture and output acceptance on the same edge: both take effect.
  - A completing capture plus a slot freed by m_ready loads immediately.
  - fifo_empty rising while inflight=1: the in-flight entry is still captured.
- Storage bound: at most one output word + one accumulator. No data is dropped or duplicated under any m_ready pattern.

Test Plan:
1. Reset/idle: r_rst=1 for 3 cycles with fifo_empty=0 -> fifo_r_en=0, m_valid=0, m_data=0, m_keep=0 throughout. After release, first pop in the first cycle after r_rst deasserts.
2. Streaming: model FIFO preloaded with 0x01..0x10, m_ready=1 -> 16 consecutive pops; words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, all m_keep=4'hF. First m_valid 5 cycles after first pop, then one word every 4 cycles.
3. Backpressure: same data, m_ready=0 for 20 cycles then 1 ->
   - Pops stop after 8 entries (output + accumulator full).
   - m_data holds 0x04030201 stable.
   - All 4 words delivered in order after release; no loss or duplication.
4. Timeout flush: FIFO supplies 0xA1,0xA2,0xA3 then stays empty, TIMEOUT=16 -> m_valid rises 16 starved cycles after the last capture, m_data=0x00A3A2A1, m_keep=4'b0111.
5. Timeout with blocked slot: previous word unaccepted (m_ready=0) when the timeout expires -> flush deferred. Partial word presented on the edge after m_ready=1 accepts the held word.
6. Reset mid-word: 2 entries captured plus 1 in flight, assert r_rst for 1 cycle -> m_valid=0, cnt cleared, in-flight entry discarded. Next word is built only from entries popped after reset.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer_if
// Description : Bundle of the FIFO read-side signals and the packed-word
//               valid/ready output of fifo_rd_packer.
//               master = packer side, slave = FIFO/downstream environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);
  logic                       fifo_empty;
  logic                       fifo_r_en;
  logic [DATA_WIDTH-1:0]      fifo_r_data;
  logic [DATA_WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]            m_keep;
  logic                       m_valid;
  logic                       m_ready;

  modport master (
    input  fifo_empty, fifo_r_data, m_ready,
    output fifo_r_en, m_data, m_keep, m_valid
  );

  modport slave (
    output fifo_empty, fifo_r_data, m_ready,
    input  fifo_r_en, m_data, m_keep, m_valid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Pops entries from an async_fifo read port, packs PACK entries
//               little-endian into one wide word and presents it on a
//               valid/ready port. A starvation timeout flushes partial words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  fifo_rd_packer_if.master      bus
);

  localparam int CW = $clog2(PACK + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int WW = DATA_WIDTH * PACK;

  localparam logic [CW-1:0] c_pack    = CW'(PACK);
  localparam logic [CW-1:0] c_pack_m1 = CW'(PACK - 1);
  localparam logic [IW-1:0] c_timeout = IW'(TIMEOUT);

  // Accumulator, fill count, pop-in-flight flag and starvation counter
  logic [WW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic [IW-1:0]   idle_q, idle_d;

  // Output word register
  logic [WW-1:0]   m_data_q, m_data_d;
  logic [PACK-1:0] m_keep_q, m_keep_d;
  logic            m_valid_q, m_valid_d;

  logic            w_slot_free;
  logic            w_pop;
  logic [CW:0]     w_occ;
  logic [WW-1:0]   w_acc_cap;
  logic [CW-1:0]   w_cnt_cap;
  logic            w_partial;
  logic            w_starved;
  logic [IW-1:0]   w_idle_inc;
  logic            w_flush;
  logic            w_load_full;
  logic [PACK-1:0] w_flush_keep;

  // Output slot can take a new word if empty or being drained this edge
  assign w_slot_free = !m_valid_q || bus.m_ready;

  // Entries already owned by the packer: captured plus the one in flight
  assign w_occ = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  // Pop while the accumulator has room; the last lane may be requested
  // early only when the completed word will be able to leave the accumulator
  assign w_pop = !r_rst && !bus.fifo_empty &&
                 ((w_occ < {1'b0, c_pack}) ||
                  ((cnt_q == c_pack_m1) && inflight_q && w_slot_free));

  assign bus.fifo_r_en = w_pop;
  assign bus.m_data    = m_data_q;
  assign bus.m_keep    = m_keep_q;
  assign bus.m_valid   = m_valid_q;

  // Accumulator view after capturing the entry returned by last cycle's pop
  always_comb begin
    w_acc_cap = acc_q;
    w_cnt_cap = cnt_q;
    if (inflight_q) begin
      for (int k = 0; k < PACK; k++) begin
        if (cnt_q == CW'(k)) begin
          w_acc_cap[k*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_r_data;
        end
      end
      w_cnt_cap = cnt_q + CW'(1);
    end
  end

  // Lanes holding data in a partial word
  always_comb begin
    w_flush_keep = '0;
    for (int k = 0; k < PACK; k++) begin
      w_flush_keep[k] = (CW'(k) < cnt_q);
    end
  end

  // Starvation tracking: a partial word with nothing coming from the FIFO.
  // The flush fires on the edge the counter reaches TIMEOUT, or later once
  // the output slot frees up while the counter sits saturated.
  assign w_partial   = (cnt_q != '0) && (cnt_q < c_pack) && !inflight_q;
  assign w_starved   = w_partial && bus.fifo_empty;
  assign w_idle_inc  = (w_starved && (idle_q != c_timeout)) ? idle_q + IW'(1) : idle_q;
  assign w_flush     = w_partial && w_slot_free && (w_idle_inc >= c_timeout);
  assign w_load_full = (w_cnt_cap == c_pack) && w_slot_free;

  // Next-state: capture, word hand-off to the output register, or flush
  always_comb begin
    acc_d      = w_acc_cap;
    cnt_d      = w_cnt_cap;
    inflight_d = w_pop;
    idle_d     = inflight_q ? '0 : w_idle_inc;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_valid_d  = m_valid_q && !bus.m_ready;
    if (w_load_full) begin
      m_data_d  = w_acc_cap;
      m_keep_d  = '1;
      m_valid_d = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
    end else if (w_flush) begin
      // Unused lanes of acc_q are still zero from the last clear
      m_data_d  = acc_q;
      m_keep_d  = w_flush_keep;
      m_valid_d = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
      idle_d    = '0;
    end
  end

  // State registers; reset also discards any pop in flight
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      idle_q     <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      idle_q     <= idle_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
    end
  end

endmodule
`default_nettype wire
